// File: rtl/adbg_tap_ctrl_if.sv
// JTAG pad and debug-top signals of the TAP controller, grouped for port use.
// Signal suffixes are from the TAP controller's point of view.
interface adbg_tap_ctrl_if;
  logic tms_i;
  logic tdi_i;
  logic tdo_o;
  logic tdo_oe_o;
  logic dbg_tdo_i;
  logic shift_dr_o;
  logic pause_dr_o;
  logic update_dr_o;
  logic capture_dr_o;
  logic debug_select_o;
  logic tlr_o;

  // TAP controller side
  modport slave (
    input  tms_i, tdi_i, dbg_tdo_i,
    output tdo_o, tdo_oe_o, shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o,
           debug_select_o, tlr_o
  );

  // Host / debug-top side
  modport master (
    output tms_i, tdi_i, dbg_tdo_i,
    input  tdo_o, tdo_oe_o, shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o,
           debug_select_o, tlr_o
  );
endinterface

// File: rtl/adbg_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register, IDCODE and
// BYPASS data registers, DR strobes for the debug top and falling-edge TDO.
module adbg_tap_ctrl #(
  parameter int unsigned          IR_WIDTH     = 4,
  parameter logic [31:0]          IDCODE_VALUE = 32'h149511C3,
  parameter logic [IR_WIDTH-1:0]  IDCODE_INSTR = 'h2,
  parameter logic [IR_WIDTH-1:0]  DEBUG_INSTR  = 'h8,
  parameter logic [IR_WIDTH-1:0]  BYPASS_INSTR = 'hF
) (
  input  logic              tck_i,
  input  logic              trstn_i,
  adbg_tap_ctrl_if.slave    tap
);

  typedef enum logic [3:0] {
    StTlr, StRti, StSelDr, StCapDr, StShDr, StEx1Dr, StPDr, StEx2Dr, StUpDr,
    StSelIr, StCapIr, StShIr, StEx1Ir, StPIr, StEx2Ir, StUpIr
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IrCapture = {{(IR_WIDTH-2){1'b0}}, 2'b01};

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q;
  logic [IR_WIDTH-1:0] ir_sr_q;
  logic [31:0]         idcode_sr_q;
  logic                bypass_q;
  logic                tdo_q;
  logic                tdo_oe_q;
  logic                sel_idcode;
  logic                sel_debug;
  logic                sel_bypass;

  // Instruction decode; every opcode that is neither IDCODE nor DEBUG is BYPASS
  assign sel_idcode = (ir_q == IDCODE_INSTR);
  assign sel_debug  = (ir_q == DEBUG_INSTR) && (DEBUG_INSTR != IDCODE_INSTR);
  assign sel_bypass = !sel_idcode && !sel_debug;

  // FSM state register
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      state_q <= StTlr;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: standard 1149.1 transition table
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTlr:   state_d = tap.tms_i ? StTlr   : StRti;
      StRti:   state_d = tap.tms_i ? StSelDr : StRti;
      StSelDr: state_d = tap.tms_i ? StSelIr : StCapDr;
      StCapDr: state_d = tap.tms_i ? StEx1Dr : StShDr;
      StShDr:  state_d = tap.tms_i ? StEx1Dr : StShDr;
      StEx1Dr: state_d = tap.tms_i ? StUpDr  : StPDr;
      StPDr:   state_d = tap.tms_i ? StEx2Dr : StPDr;
      StEx2Dr: state_d = tap.tms_i ? StUpDr  : StShDr;
      StUpDr:  state_d = tap.tms_i ? StSelDr : StRti;
      StSelIr: state_d = tap.tms_i ? StTlr   : StCapIr;
      StCapIr: state_d = tap.tms_i ? StEx1Ir : StShIr;
      StShIr:  state_d = tap.tms_i ? StEx1Ir : StShIr;
      StEx1Ir: state_d = tap.tms_i ? StUpIr  : StPIr;
      StPIr:   state_d = tap.tms_i ? StEx2Ir : StPIr;
      StEx2Ir: state_d = tap.tms_i ? StUpIr  : StShIr;
      StUpIr:  state_d = tap.tms_i ? StSelDr : StRti;
    endcase
  end

  // FSM outputs: strobes are a pure decode of the current state
  always_comb begin
    tap.shift_dr_o     = (state_q == StShDr);
    tap.pause_dr_o     = (state_q == StPDr);
    tap.update_dr_o    = (state_q == StUpDr);
    tap.capture_dr_o   = (state_q == StCapDr);
    tap.tlr_o          = (state_q == StTlr);
    tap.debug_select_o = sel_debug;
    tap.tdo_o          = tdo_q;
    tap.tdo_oe_o       = tdo_oe_q;
  end

  // Instruction register: capture/shift, then latch on leaving Update-IR
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      ir_sr_q <= '0;
      ir_q    <= IDCODE_INSTR;
    end else begin
      if (state_q == StCapIr) begin
        ir_sr_q <= IrCapture;
      end else if (state_q == StShIr) begin
        ir_sr_q <= {tap.tdi_i, ir_sr_q[IR_WIDTH-1:1]};
      end
      if (state_q == StUpIr) begin
        ir_q <= ir_sr_q;
      end
      // Forcing on the edge that enters TLR keeps debug_select low from the
      // very first TLR cycle; Update-IR can never step straight into TLR.
      if (state_d == StTlr) begin
        ir_q <= IDCODE_INSTR;
      end
    end
  end

  // IDCODE and BYPASS data registers; pause/exit states hold them
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      idcode_sr_q <= '0;
      bypass_q    <= 1'b0;
    end else begin
      if (sel_idcode) begin
        if (state_q == StCapDr) begin
          idcode_sr_q <= IDCODE_VALUE;
        end else if (state_q == StShDr) begin
          idcode_sr_q <= {tap.tdi_i, idcode_sr_q[31:1]};
        end
      end
      if (sel_bypass) begin
        if (state_q == StCapDr) begin
          bypass_q <= 1'b0;
        end else if (state_q == StShDr) begin
          bypass_q <= tap.tdi_i;
        end
      end
    end
  end

  // TDO mux, registered on the falling edge of TCK
  always_ff @(negedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_oe_q <= (state_q == StShIr) || (state_q == StShDr);
      if (state_q == StShIr) begin
        tdo_q <= ir_sr_q[0];
      end else if (state_q == StShDr) begin
        if (sel_idcode) begin
          tdo_q <= idcode_sr_q[0];
        end else if (sel_debug) begin
          tdo_q <= tap.dbg_tdo_i;
        end else begin
          tdo_q <= bypass_q;
        end
      end else begin
        tdo_q <= 1'b0;
      end
    end
  end

endmodule
